pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 57 +++++
 rtl/pipe_ctrl_hazard_detect.sv | 28 ++
 rtl/pipe_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions for the pipeline controller: FSM states, RV32 opcode
// fields, the bubble encoding and per-cycle pipeline control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEMWAIT,
    ST_HALT
  } state_e;

  // instr[6:2] opcode field values
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [31:0] BUBBLE   = 32'h0000_0013;
  localparam int          WAIT_W   = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic flush_ifid;
    logic flush_idex;
    logic flush_memwb;
  } ctl_t;

  localparam ctl_t CTL_NONE  = '0;
  localparam ctl_t CTL_FREEZE = '{stall_pc: 1'b1, stall_ifid: 1'b1, stall_idex: 1'b1,
                                  stall_exmem: 1'b1, flush_ifid: 1'b0, flush_idex: 1'b0,
                                  flush_memwb: 1'b1};

  function automatic logic [4:0] opcode(input logic [31:0] instr);
    return instr[6:2];
  endfunction

  function automatic logic uses_rs1(input logic [4:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [4:0] opc);
    return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

  // ecall/ebreak: SYSTEM opcode with funct3 == 000
  function automatic logic is_halt(input logic [4:0] opc, input logic [2:0] funct3);
    return (opc == OPC_SYSTEM) && (funct3 == 3'b000);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds a source
// register actually read by the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr_id,
  input  logic [31:0] instr_ex,
  input  logic        memread_ex,
  output logic        loaduse
);

  logic [4:0] rd_ex, rs1_id, rs2_id, opc_id;
  logic       hit_rs1, hit_rs2;
  logic       unused_bits;

  assign rd_ex  = instr_ex[11:7];
  assign rs1_id = instr_id[19:15];
  assign rs2_id = instr_id[24:20];
  assign opc_id = opcode(instr_id);

  assign hit_rs1 = (rd_ex == rs1_id) && uses_rs1(opc_id);
  assign hit_rs2 = (rd_ex == rs2_id) && uses_rs2(opc_id);
  assign loaduse = memread_ex && (rd_ex != 5'd0) && (hit_rs1 || hit_rs2);

  assign unused_bits = ^{instr_ex[31:12], instr_ex[6:0], instr_id[31:25],
                         instr_id[14:7], instr_id[1:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates memory-wait freeze, branch redirect and
// load-use stall, tracks halt, a memory-wait watchdog and stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_id,
  input  logic [31:0] instr_ex,
  input  logic [31:0] instr_wb,
  input  logic        memread_ex,
  input  logic        pctaken_ex,
  input  logic        dmem_req_mem,
  input  logic        dmem_ready,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_memwb,
  output logic        halted,
  output logic        wd_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] TO = WAIT_W'(TIMEOUT);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              wd_q, wd_set;
  logic              loaduse, redirect, mem_stall;
  ctl_t              ctl;
  logic              unused_bits;

  hazard_detect u_hazard (
    .instr_id   (instr_id),
    .instr_ex   (instr_ex),
    .memread_ex (memread_ex),
    .loaduse    (loaduse)
  );

  always_comb begin
    ctl       = CTL_NONE;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    redirect  = 1'b0;
    mem_stall = 1'b0;
    unique case (state)
      ST_RUN, ST_MEMWAIT: begin
        if ((state == ST_RUN) ? (dmem_req_mem && !dmem_ready) : !dmem_ready) begin
          ctl       = CTL_FREEZE;
          mem_stall = 1'b1;
          state_nxt = ST_MEMWAIT;
          if (state == ST_RUN)
            wait_nxt = WAIT_W'(1);
          else if (wait_cnt != WAIT_MAX)
            wait_nxt = wait_cnt + WAIT_W'(1);
        end else begin
          // Front-end hazards also apply on the cycle memory-wait releases.
          state_nxt = ST_RUN;
          wait_nxt  = '0;
          if (pctaken_ex) begin
            ctl.flush_ifid = 1'b1;
            ctl.flush_idex = 1'b1;
            redirect       = 1'b1;
          end else if (loaduse) begin
            ctl.stall_pc   = 1'b1;
            ctl.stall_ifid = 1'b1;
            ctl.flush_idex = 1'b1;
          end
        end
      end
      ST_HALT: ctl = CTL_FREEZE;
      default: state_nxt = ST_RUN;
    endcase
    if (is_halt(opcode(instr_wb), instr_wb[14:12]))
      state_nxt = ST_HALT;
  end

  assign wd_set = mem_stall && (wait_nxt >= TO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      wd_q      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (wd_set) wd_q <= 1'b1;
      if (ctl.stall_pc && state != ST_HALT) stall_cnt <= stall_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_pc    = ctl.stall_pc;
  assign stall_ifid  = ctl.stall_ifid;
  assign stall_idex  = ctl.stall_idex;
  assign stall_exmem = ctl.stall_exmem;
  assign flush_ifid  = ctl.flush_ifid;
  assign flush_idex  = ctl.flush_idex;
  assign flush_memwb = ctl.flush_memwb;
  assign halted      = (state == ST_HALT);
  assign wd_err      = wd_q;

  assign unused_bits = ^{instr_wb[31:15], instr_wb[11:7], instr_wb[1:0]};

endmodule
